snoopy_bus_arbiter: RTL and testbench

Shared-bus arbiter and command broadcaster for the snoopy invalidate-protocol cache cluster. It sits directly upstream of every cache controller's CPU-side bus port. It grants one cache controller's bus request at a time and broadcasts the owner's bus command and cache number to all snoopy controllers. It also serialises the invalidate acknowledgements returned by the snoopers back to the owner, one per cycle.

---
 rtl/snoopy_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_snoopy_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_bus_arbiter.sv
// snoopy_bus_arbiter: shared-bus arbiter, command broadcaster and invalidate-ack serialiser for a snoopy cache cluster.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   request             : per-cache bus request
//   cpuCommandOut       : per-cache requested bus command (COMMAND_WIDTH slices)
//   snoopyCommandOut    : per-cache snoopy response (BUS_INVALIDATE = invalidate done)
//   grant               : one-hot bus ownership, zero when idle
//   snoopyCommandIn     : broadcast command of the owner, NONE when idle
//   snoopyCacheNumber   : index of the owner
//   cpuCommandIn        : single-cycle BUS_INVALIDATE ack pulse to the owner
//   cacheNumberIn       : index of the acknowledging cache
// Build option SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN: lowest request index always wins (default is round-robin).
module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_CACHES = 4,
  parameter int COMMAND_WIDTH = 2,
  parameter int CACHE_NUMBER_WIDTH = $clog2(NUMBER_OF_CACHES)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUMBER_OF_CACHES-1:0]                 request,
  input  logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0]   cpuCommandOut,
  input  logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0]   snoopyCommandOut,
  output logic [NUMBER_OF_CACHES-1:0]                 grant,
  output logic [COMMAND_WIDTH-1:0]                    snoopyCommandIn,
  output logic [CACHE_NUMBER_WIDTH-1:0]               snoopyCacheNumber,
  output logic [COMMAND_WIDTH-1:0]                    cpuCommandIn,
  output logic [CACHE_NUMBER_WIDTH-1:0]               cacheNumberIn
);
  localparam int N = NUMBER_OF_CACHES;
  localparam int W = COMMAND_WIDTH;
  localparam int CW = CACHE_NUMBER_WIDTH;
  localparam logic [W-1:0] NONE = '0;
  localparam logic [W-1:0] BUS_INVALIDATE = W'(3);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state, state_d;
  logic [CW-1:0] winner, owner_d, scan_ptr, scan_d, scan_nx, cache_d;
  logic [N-1:0] acked, acked_d, grant_d;
  logic [W-1:0] bcast_d, cpu_d;
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
    return (x == CW'(N-1)) ? '0 : x + 1'b1;
  endfunction
`ifdef SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    winner = '0;
    for (int i = N-1; i >= 0; i--) winner = request[i] ? CW'(i) : winner;
  end
`else
  logic [CW-1:0] prio_ptr, rr_idx;
  logic found;
  // first set request at or above prio_ptr, wrapping
  always_comb begin
    winner = prio_ptr;
    found = 1'b0;
    rr_idx = prio_ptr;
    for (int i = 0; i < N; i++) begin
      rr_idx = CW'((int'(prio_ptr) + i) % N);
      if (!found && request[rr_idx]) begin
        winner = rr_idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) prio_ptr <= '0;
    else if (state == GRANTED && !request[snoopyCacheNumber]) prio_ptr <= inc(snoopyCacheNumber);
`endif
  always_comb begin
    state_d = state;
    owner_d = snoopyCacheNumber;
    grant_d = grant;
    bcast_d = snoopyCommandIn;
    scan_d = scan_ptr;
    acked_d = acked;
    cpu_d = NONE;
    cache_d = cacheNumberIn;
    // next scan position, never landing on the owner
    scan_nx = inc(scan_ptr);
    scan_nx = (scan_nx == snoopyCacheNumber) ? inc(scan_nx) : scan_nx;
    if (state == IDLE) begin
      if (|request) begin
        state_d = GRANTED;
        owner_d = winner;
        grant_d = N'(1) << winner;
        bcast_d = cpuCommandOut[winner*W +: W];
        scan_d = (winner == '0) ? CW'(1) : '0;
        acked_d = '0;
      end
    end else if (!request[snoopyCacheNumber]) begin
      state_d = IDLE;
      grant_d = '0;
      bcast_d = NONE;
    end else begin
      // owner may change its command without losing the bus
      bcast_d = cpuCommandOut[snoopyCacheNumber*W +: W];
      if (snoopyCommandIn == BUS_INVALIDATE) begin
        scan_d = scan_nx;
        if (snoopyCommandOut[scan_ptr*W +: W] == BUS_INVALIDATE && !acked[scan_ptr]) begin
          cpu_d = BUS_INVALIDATE;
          cache_d = scan_ptr;
          acked_d[scan_ptr] = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      snoopyCommandIn <= NONE;
      snoopyCacheNumber <= '0;
      cpuCommandIn <= NONE;
      cacheNumberIn <= '0;
      scan_ptr <= '0;
      acked <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      snoopyCommandIn <= bcast_d;
      snoopyCacheNumber <= owner_d;
      cpuCommandIn <= cpu_d;
      cacheNumberIn <= cache_d;
      scan_ptr <= scan_d;
      acked <= acked_d;
    end
endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// tb_snoopy_bus_arbiter: directed and randomized bench for snoopy_bus_arbiter against a behavioural model.
module tb_snoopy_bus_arbiter;
  localparam int N = 4;
  localparam int NONE = 0, READ = 1, WB = 2, INV = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] request = '0;
  logic [7:0] cpu_cmd = '0;
  logic [7:0] snoop = '0;
  logic [3:0] grant;
  logic [1:0] snoopyCommandIn, snoopyCacheNumber, cpuCommandIn, cacheNumberIn;
  int checks = 0;
  int errors = 0;
  int m_busy, m_owner, m_cmd, m_prio, m_scan, m_cpu, m_cnum;
  bit [3:0] m_acked;
  int acks[$];

  snoopy_bus_arbiter dut (
    .clock(clock), .reset(reset), .request(request),
    .cpuCommandOut(cpu_cmd), .snoopyCommandOut(snoop),
    .grant(grant), .snoopyCommandIn(snoopyCommandIn), .snoopyCacheNumber(snoopyCacheNumber),
    .cpuCommandIn(cpuCommandIn), .cacheNumberIn(cacheNumberIn)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cmd = NONE; m_prio = 0; m_scan = 0; m_cpu = NONE; m_cnum = 0; m_acked = '0;
  endtask

  function automatic int pick();
`ifdef SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (request[i]) return i;
`else
    for (int i = 0; i < N; i++) if (request[(m_prio + i) % N]) return (m_prio + i) % N;
`endif
    return 0;
  endfunction

  function automatic int slice(input logic [7:0] v, input int i);
    return int'(v[i*2 +: 2]);
  endfunction

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    m_cpu = NONE;
    if (m_busy == 0) begin
      if (request != 0) begin
        m_owner = pick();
        m_busy = 1;
        m_cmd = slice(cpu_cmd, m_owner);
        m_scan = (m_owner == 0) ? 1 : 0;
        m_acked = '0;
      end
    end else if (!request[m_owner]) begin
      m_busy = 0;
      m_cmd = NONE;
      m_prio = (m_owner + 1) % N;
    end else begin
      if (m_cmd == INV) begin
        if (slice(snoop, m_scan) == INV && !m_acked[m_scan]) begin
          m_cpu = INV;
          m_cnum = m_scan;
          m_acked[m_scan] = 1'b1;
        end
        m_scan = (m_scan + 1) % N;
        if (m_scan == m_owner) m_scan = (m_scan + 1) % N;
      end
      m_cmd = slice(cpu_cmd, m_owner);
    end
  endtask

  task automatic compare();
    check("grant", 32'(grant), m_busy != 0 ? 32'(1 << m_owner) : 32'd0);
    check("snoopyCommandIn", 32'(snoopyCommandIn), 32'(m_cmd));
    check("snoopyCacheNumber", 32'(snoopyCacheNumber), 32'(m_owner));
    check("cpuCommandIn", 32'(cpuCommandIn), 32'(m_cpu));
    check("cacheNumberIn", 32'(cacheNumberIn), 32'(m_cnum));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic set_cmd(input int i, input logic [1:0] c);
    cpu_cmd[i*2 +: 2] = c;
  endtask

  task automatic set_snoop(input int i, input logic [1:0] c);
    snoop[i*2 +: 2] = c;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_grant", 32'(grant), 32'd0);

    // round-robin: all request, each owner holds three cycles
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_owner", 32'(idx_of(grant)), 32'(k % N));
      tick();
      tick();
      request = 4'b1111 & ~grant;
      tick();
      check("rr_idle", 32'(grant), 32'd0);
      request = 4'b1111;
    end
    request = '0;
    tick();
    tick();

    // single read by cache 2
    request = 4'b0100;
    set_cmd(2, 2'(READ));
    tick();
    check("rd_grant", 32'(grant), 32'b0100);
    check("rd_cmd", 32'(snoopyCommandIn), 32'(READ));
    check("rd_num", 32'(snoopyCacheNumber), 32'd2);
    request = '0;
    tick();
    check("rd_release", 32'(grant), 32'd0);
    check("rd_release_cmd", 32'(snoopyCommandIn), 32'(NONE));

    // command switch writeback -> read while holding the bus
    request = 4'b1000;
    set_cmd(3, 2'(WB));
    tick();
    check("sw_grant", 32'(grant), 32'b1000);
    check("sw_wb", 32'(snoopyCommandIn), 32'(WB));
    set_cmd(3, 2'(READ));
    tick();
    check("sw_hold", 32'(grant), 32'b1000);
    check("sw_rd", 32'(snoopyCommandIn), 32'(READ));
    request = '0;
    tick();

    // invalidate acks: owner 1, responders 0,2 then 3
    request = 4'b0010;
    set_cmd(1, 2'(INV));
    acks.delete();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2) begin
        set_snoop(0, 2'(INV));
        set_snoop(2, 2'(INV));
      end
      if (c == 5) set_snoop(3, 2'(INV));
      if (c == 6) set_snoop(1, 2'(INV));
      if (cpuCommandIn == 2'(INV)) acks.push_back(int'(cacheNumberIn));
    end
    check("inv_count", 32'(acks.size()), 32'd3);
    if (acks.size() == 3) begin
      check("inv_ack0", 32'(acks[0]), 32'd2);
      check("inv_ack1", 32'(acks[1]), 32'd0);
      check("inv_ack2", 32'(acks[2]), 32'd3);
    end
    request = '0;
    snoop = '0;
    tick();
    tick();

    // asynchronous reset in the middle of a transaction
    request = 4'b0010;
    set_cmd(1, 2'(READ));
    tick();
    check("rst_pre_grant", 32'(grant), 32'b0010);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_grant", 32'(grant), 32'd0);
    check("rst_async_cmd", 32'(snoopyCommandIn), 32'(NONE));
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    check("rst_regrant", 32'(grant), 32'b0010);
    request = '0;
    tick();

`ifdef SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN
    request = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fp_owner", 32'(grant), 32'b0010);
      request = 4'b1000;
      tick();
      request = 4'b1010;
    end
    request = '0;
    tick();
`endif

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(3) == 0) request = 4'($urandom);
      if ($urandom_range(2) == 0) cpu_cmd = 8'($urandom);
      snoop = 8'($urandom);
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
